mult_seq: RTL and testbench

//  Multi-cycle sequencer for unsigned MIPS MULTU. Reuses one alu instance (op_add) as the adder of a

---
 rtl/mult_seq_pkg.sv | 19 +
 rtl/alu.sv | 26 ++
 rtl/mux2to1.sv | 13 +
 rtl/mult_seq.sv | 122 ++++++++++++
 tb/tb_mult_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// Shared encodings for the multi-cycle multiplier and its ALU.
package mult_seq_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        op_add = 2'b00,
        op_sub = 2'b01,
        op_ori = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Small datapath ALU: add, subtract, or, with zero flag.
module alu
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          ctrl_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zf_o
);

    always_comb begin
        out_o = '0;
        unique case (ctrl_i)
            op_add:  out_o = a_i + b_i;
            op_sub:  out_o = a_i - b_i;
            op_ori:  out_o = a_i | b_i;
            default: out_o = '0;
        endcase
    end

    assign zf_o = (out_o == '0);

endmodule

// File: rtl/mux2to1.sv
// Generic two-input word multiplexer.
module mux2to1 #(
    parameter int n = 32
) (
    input  logic [n-1:0] in0_i,
    input  logic [n-1:0] in1_i,
    input  logic         sel_i,
    output logic [n-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mult_seq.sv
// Unsigned MULTU sequencer: shift-add over 32 cycles using the shared ALU adder.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic              run;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
    logic              alu_zf_unused;
    logic              carry;
    logic [WIDTH-1:0]  acc_nx, mq_nx;

    assign run = (state_q == S_RUN);

    mux2to1 #(.n(WIDTH)) u_mux (
        .in0_i (WIDTH'(0)),
        .in1_i (mcand_q),
        .sel_i (mq_q[0]),
        .out_o (addend)
    );

    // ALU sees zero operands outside RUN so it stays quiet.
    assign alu_a = run ? acc_q  : '0;
    assign alu_b = run ? addend : '0;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .ctrl_i (op_add),
        .out_o  (alu_out),
        .zf_o   (alu_zf_unused)
    );

    assign carry  = (alu_out < acc_q);
    assign acc_nx = {carry, alu_out[WIDTH-1:1]};
    assign mq_nx  = {alu_out[0], mq_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    mq_d    = op_b;
                    mcand_d = op_a;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_nx;
                    mq_d  = mq_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        hi_d    = acc_nx;
                        lo_d    = mq_nx;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = run;
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq against a 64-bit arithmetic product model.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    // Model: last completed product, held until the next completion.
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Accept happens on the next posedge; returns in RUN cycle 0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Waits (bounded) for done, expecting exp_n cycles, then checks the product.
    task automatic wait_done(input string tag, input int exp_n,
                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int n;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        p = {32'b0, a} * {32'b0, b};
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_prod"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic seen;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(32'd3, 32'd5);
        check("t1_busy0", 64'(busy), 64'd1);
        wait_done("t1", 32, 32'd3, 32'd5);
        check("t1_const", {hi, lo}, 64'h0000_0000_0000_000F);
        @(negedge clk);
        check("t1_pulse", 64'(done), 64'd0);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("t2", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        launch(32'h1234_5678, 32'd0);
        wait_done("t3a", 32, 32'h1234_5678, 32'd0);
        launch(32'h0001_0000, 32'h0001_0000);
        wait_done("t3b", 32, 32'h0001_0000, 32'h0001_0000);
        check("t3_const", {hi, lo}, 64'h0000_0001_0000_0000);

        // Start during RUN is ignored.
        @(negedge clk);
        launch(32'd7, 32'd6);
        repeat (10) @(negedge clk);
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", 21, 32'd7, 32'd6);
        check("t4_const", {hi, lo}, 64'd42);

        // Flush mid-run: no done, result held.
        @(negedge clk);
        launch(32'd100, 32'd100);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            seen |= done;
            @(negedge clk);
        end
        check("t5_nodone", 64'(seen), 64'd0);
        check("t5_hold", {hi, lo}, 64'd42);
        launch(32'd2, 32'd2);
        wait_done("t5b", 32, 32'd2, 32'd2);

        // Flush on the last RUN cycle beats completion.
        @(negedge clk);
        launch(32'd11, 32'd13);
        repeat (31) @(negedge clk);
        check("t7_lastbusy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        check("t7_hold", {hi, lo}, {exp_hi, exp_lo});

        // Start together with flush in IDLE is accepted.
        flush = 1'b1;
        launch(32'd123, 32'd456);
        flush = 1'b0;
        wait_done("t8", 32, 32'd123, 32'd456);

        // Back-to-back from DONE: hi/lo held until next completion.
        launch(32'hDEAD_BEEF, 32'h0000_1000);
        check("t9_hold", {hi, lo}, {exp_hi, exp_lo});
        check("t9_busy", 64'(busy), 64'd1);
        wait_done("t9", 32, 32'hDEAD_BEEF, 32'h0000_1000);

        // Asynchronous reset mid-run.
        @(negedge clk);
        launch(32'd7, 32'd7);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst", {28'b0, busy, done, 2'b0, hi}, 64'd0);
        check("t6_lo", 64'(lo), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(32'd3, 32'd5);
        wait_done("t6b", 32, 32'd3, 32'd5);

        // Random operations, some back-to-back from DONE.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = 32'hFFFF_FFFF;
            if (i % 5 == 2) b = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            launch(a, b);
            wait_done("rnd", 32, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
